// File: rtl/hex_ascii_pkg.sv
// Shared constants and the nibble-to-ASCII mapping used by the hex/ASCII converter.
package hex_ascii_pkg;

    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble, input logic uppercase);
        logic [7:0] base;
        if (nibble < 4'd10) begin
            return ASCII_ZERO + {4'd0, nibble};
        end
        base = uppercase ? ASCII_UPPER_A : ASCII_LOWER_A;
        return base + {4'd0, nibble} - 8'd10;
    endfunction

endpackage

// File: rtl/hex_digit_ascii.sv
// Purely combinational converter from one hex digit to its printable ASCII code.
module hex_digit_ascii
    import hex_ascii_pkg::*;
#(
    parameter int UPPERCASE = 1
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = nibble_to_ascii(nibble, UPPERCASE != 0);

endmodule

// File: rtl/hex_ascii_conv.sv
// Converts a packed hex word into a registered parallel ASCII image plus a
// valid/ready character stream (MSB digit first) for the LCD write sequencer.
module hex_ascii_conv
    import hex_ascii_pkg::*;
#(
    parameter int NIBBLES   = 32,
    parameter int UPPERCASE = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4*NIBBLES-1:0]         in_data,
    output logic                         par_valid,
    output logic [8*NIBBLES-1:0]         par_ascii,
    output logic                         char_valid,
    input  logic                         char_ready,
    output logic [7:0]                   char_data,
    output logic [$clog2(NIBBLES)-1:0]   char_index,
    output logic                         char_last
);

    localparam int IDX_W = $clog2(NIBBLES);

    logic [4*NIBBLES-1:0] data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 par_valid_q, par_valid_d;
    logic [8*NIBBLES-1:0] par_ascii_q, par_ascii_d;
    logic                 char_valid_q, char_valid_d;
    logic [IDX_W-1:0]     char_index_q, char_index_d;
    logic [7:0]           char_data_q, char_data_d;

    logic [8*NIBBLES-1:0] par_conv;
    logic [IDX_W-1:0]     next_pos;
    logic [3:0]           stream_nib;
    logic [3:0]           stream_in;
    logic [7:0]           stream_ascii;
    logic                 accept;
    logic                 advance;
    logic                 at_last;

    for (genvar g = 0; g < NIBBLES; g++) begin : g_par
        hex_digit_ascii #(.UPPERCASE(UPPERCASE)) u_digit (
            .nibble (in_data[4*g +: 4]),
            .ascii  (par_conv[8*g +: 8])
        );
    end

    hex_digit_ascii #(.UPPERCASE(UPPERCASE)) u_stream_digit (
        .nibble (stream_in),
        .ascii  (stream_ascii)
    );

    assign accept  = in_valid & ~busy_q;
    assign advance = char_valid_q & char_ready;
    assign at_last = (char_index_q == IDX_W'(NIBBLES - 1));

    // On accept the stream digit comes straight from in_data; otherwise it is
    // the captured digit that follows the current index (MSB to LSB).
    always_comb begin
        next_pos   = IDX_W'(NIBBLES - 2) - char_index_q;
        stream_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (IDX_W'(i) == next_pos) begin
                stream_nib = data_q[4*i +: 4];
            end
        end
        stream_in = accept ? in_data[4*(NIBBLES-1) +: 4] : stream_nib;
    end

    always_comb begin
        data_d       = data_q;
        busy_d       = busy_q;
        par_valid_d  = 1'b0;
        par_ascii_d  = par_ascii_q;
        char_valid_d = char_valid_q;
        char_index_d = char_index_q;
        char_data_d  = char_data_q;
        if (accept) begin
            data_d       = in_data;
            busy_d       = 1'b1;
            par_ascii_d  = par_conv;
            par_valid_d  = 1'b1;
            char_valid_d = 1'b1;
            char_index_d = '0;
            char_data_d  = stream_ascii;
        end else if (advance) begin
            if (at_last) begin
                char_valid_d = 1'b0;
                busy_d       = 1'b0;
            end else begin
                char_index_d = char_index_q + 1'b1;
                char_data_d  = stream_ascii;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q       <= '0;
            busy_q       <= 1'b0;
            par_valid_q  <= 1'b0;
            par_ascii_q  <= '0;
            char_valid_q <= 1'b0;
            char_index_q <= '0;
            char_data_q  <= '0;
        end else begin
            data_q       <= data_d;
            busy_q       <= busy_d;
            par_valid_q  <= par_valid_d;
            par_ascii_q  <= par_ascii_d;
            char_valid_q <= char_valid_d;
            char_index_q <= char_index_d;
            char_data_q  <= char_data_d;
        end
    end

    assign in_ready   = ~busy_q;
    assign par_valid  = par_valid_q;
    assign par_ascii  = par_ascii_q;
    assign char_valid = char_valid_q;
    assign char_data  = char_data_q;
    assign char_index = char_index_q;
    assign char_last  = char_valid_q & at_last;

endmodule

// File: tb/tb_hex_ascii_conv.sv
// Bench for hex_ascii_conv: uppercase 32-digit build plus a lowercase 4-digit build.
module tb_hex_ascii_conv;

    localparam int N  = 32;
    localparam int NL = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;

    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [4*N-1:0] in_data = '0;
    logic           par_valid;
    logic [8*N-1:0] par_ascii;
    logic           char_valid;
    logic           char_ready = 1'b0;
    logic [7:0]     char_data;
    logic [4:0]     char_index;
    logic           char_last;

    logic            in_valid_lc = 1'b0;
    logic            in_ready_lc;
    logic [4*NL-1:0] in_data_lc = '0;
    logic            par_valid_lc;
    logic [8*NL-1:0] par_ascii_lc;
    logic            char_valid_lc;
    logic            char_ready_lc = 1'b0;
    logic [7:0]      char_data_lc;
    logic [1:0]      char_index_lc;
    logic            char_last_lc;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    hex_ascii_conv #(.NIBBLES(N), .UPPERCASE(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .par_valid(par_valid), .par_ascii(par_ascii),
        .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
        .char_index(char_index), .char_last(char_last)
    );

    hex_ascii_conv #(.NIBBLES(NL), .UPPERCASE(0)) dut_lc (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid_lc), .in_ready(in_ready_lc), .in_data(in_data_lc),
        .par_valid(par_valid_lc), .par_ascii(par_ascii_lc),
        .char_valid(char_valid_lc), .char_ready(char_ready_lc), .char_data(char_data_lc),
        .char_index(char_index_lc), .char_last(char_last_lc)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_char(input logic [127:0] w, input int i, input bit up);
        int n;
        n = int'((w >> (4*i)) & 128'hF);
        if (n < 10) return 8'(48 + n);
        return up ? 8'(65 + n - 10) : 8'(97 + n - 10);
    endfunction

    function automatic logic [255:0] ref_image(input logic [127:0] w, input int nib, input bit up);
        logic [255:0] img;
        img = '0;
        for (int i = 0; i < nib; i++) img[8*i +: 8] = ref_char(w, i, up);
        return img;
    endfunction

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [127:0] w);
        int budget;
        budget = 0;
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("accept_wait", {255'd0, in_ready}, 256'd1);
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("par_image", par_ascii, ref_image(w, N, 1'b1));
        exp_q.delete();
        for (int i = N - 1; i >= 0; i--) exp_q.push_back(ref_char(w, i, 1'b1));
    endtask

    // Consumes the stream up to position stop_at; stalls stall_len cycles at stall_idx.
    task automatic consume(input logic [127:0] w, input int stall_idx, input int stall_len,
                           input bit rand_ready, input bit poke_input, input int stop_at);
        int k, cyc, stalled;
        logic rdy;
        k = 0; cyc = 0; stalled = 0;
        while (k < stop_at && cyc < 400) begin
            check("char_valid", {255'd0, char_valid}, 256'd1);
            check("char_data", {248'd0, char_data}, {248'd0, exp_q[k]});
            check("char_index", {251'd0, char_index}, 256'(k));
            check("char_last", {255'd0, char_last}, {255'd0, k == N - 1});
            check("in_ready_busy", {255'd0, in_ready}, 256'd0);
            check("par_valid", {255'd0, par_valid}, {255'd0, cyc == 0});
            check("par_hold", par_ascii, ref_image(w, N, 1'b1));
            if (k == stall_idx && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else if (rand_ready) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            char_ready = rdy;
            if (poke_input) begin
                in_valid = $urandom_range(0, 1) != 0;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        in_valid   = 1'b0;
        char_ready = 1'b0;
        check("stream_done", 256'(k), 256'(stop_at));
        if (stop_at == N) begin
            check("in_ready_after", {255'd0, in_ready}, 256'd1);
            check("char_valid_after", {255'd0, char_valid}, 256'd0);
            check("par_after_stream", par_ascii, ref_image(w, N, 1'b1));
        end
    endtask

    task automatic lc_word(input logic [15:0] w);
        int budget;
        budget = 0;
        while (!in_ready_lc && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("lc_accept_wait", {255'd0, in_ready_lc}, 256'd1);
        in_data_lc  = w;
        in_valid_lc = 1'b1;
        @(negedge clk);
        in_valid_lc = 1'b0;
        check("lc_par_valid", {255'd0, par_valid_lc}, 256'd1);
        check("lc_par_image", {224'd0, par_ascii_lc}, ref_image({112'd0, w}, NL, 1'b0));
        char_ready_lc = 1'b1;
        for (int k = 0; k < NL; k++) begin
            check("lc_char_data", {248'd0, char_data_lc}, {248'd0, ref_char({112'd0, w}, NL - 1 - k, 1'b0)});
            check("lc_char_last", {255'd0, char_last_lc}, {255'd0, k == NL - 1});
            @(negedge clk);
        end
        char_ready_lc = 1'b0;
        check("lc_in_ready_after", {255'd0, in_ready_lc}, 256'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [127:0] w;
        logic [255:0] img;

        repeat (3) @(negedge clk);
        check("rst_in_ready_low", {255'd0, in_ready}, 256'd1);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {255'd0, in_ready}, 256'd1);
        check("rst_char_valid", {255'd0, char_valid}, 256'd0);
        check("rst_par_valid", {255'd0, par_valid}, 256'd0);
        check("rst_par_ascii", par_ascii, 256'd0);
        check("rst_char_index", {251'd0, char_index}, 256'd0);
        check("rst_char_data", {248'd0, char_data}, 256'd0);

        w = 128'h19a09ae93df4c6f8e3e28d48be2b2a08;
        send_word(w);
        img = par_ascii;
        check("byte31", {248'd0, img[8*31 +: 8]}, 256'h31);
        check("byte30", {248'd0, img[8*30 +: 8]}, 256'h39);
        check("byte29", {248'd0, img[8*29 +: 8]}, 256'h41);
        check("byte28", {248'd0, img[8*28 +: 8]}, 256'h30);
        check("byte0", {248'd0, img[7:0]}, 256'h38);
        consume(w, -1, 0, 1'b0, 1'b0, N);

        w = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        send_word(w);
        check("first_char_2", {248'd0, char_data}, 256'h32);
        consume(w, -1, 0, 1'b0, 1'b0, N);

        // backpressure at index 3 with competing input words
        w = {$urandom, $urandom, $urandom, $urandom};
        send_word(w);
        consume(w, 3, 5, 1'b0, 1'b1, N);

        send_word({N{4'h0}});
        check("all_zero", par_ascii, {N{8'h30}});
        consume({N{4'h0}}, -1, 0, 1'b0, 1'b0, N);
        send_word({N{4'hF}});
        check("all_f", par_ascii, {N{8'h46}});
        consume({N{4'hF}}, -1, 0, 1'b1, 1'b0, N);

        for (int t = 0; t < 4; t++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            send_word(w);
            consume(w, $urandom_range(0, N - 1), $urandom_range(0, 4), 1'b1, 1'b1, N);
        end

        lc_word(16'h0000);
        check("lc_all_zero", {224'd0, par_ascii_lc}, {224'd0, {NL{8'h30}}});
        lc_word(16'hFFFF);
        check("lc_all_f", {224'd0, par_ascii_lc}, {224'd0, {NL{8'h66}}});
        lc_word(16'hA5C9);
        lc_word(16'($urandom));

        // asynchronous reset mid-stream at index 10
        w = {$urandom, $urandom, $urandom, $urandom};
        send_word(w);
        consume(w, -1, 0, 1'b0, 1'b0, 10);
        check("pre_rst_index", {251'd0, char_index}, 256'd10);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_char_valid", {255'd0, char_valid}, 256'd0);
        check("midrst_in_ready", {255'd0, in_ready}, 256'd1);
        check("midrst_char_index", {251'd0, char_index}, 256'd0);
        check("midrst_par_ascii", par_ascii, 256'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        w = {$urandom, $urandom, $urandom, $urandom};
        send_word(w);
        consume(w, -1, 0, 1'b1, 1'b0, N);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hex_ascii_conv.md
Name: hex_ascii_conv

Overview:
- Converts a packed hexadecimal word into printable ASCII characters. Each 4-bit nibble becomes one 8-bit character: 0-9 map to 0x30-0x39, and A-F map to 0x41-0x46 (uppercase) or 0x61-0x66 (lowercase).
- Sits between the AES data memory and the character-LCD driver.
- Produces two outputs from each accepted word:
  - a registered parallel image of all characters;
  - a serial character stream with valid/ready flow control, MSB nibble first, which feeds the LCD write sequencer.

Parameters:
- NIBBLES, 32: number of hex digits per input word. Must be 2 or more.
- UPPERCASE, 1: 1 selects 'A'-'F' (0x41-0x46); 0 selects 'a'-'f' (0x61-0x66).

Ports:
- clk: in, 1. Single clock; all state updates on its rising edge.
- reset_n: in, 1. Asynchronous, active-low reset.
- in_valid: in, 1. Input word offered.
- in_ready: out, 1. Block can accept a word; equals NOT busy.
- in_data: in, 4*NIBBLES. Hex word; nibble i is in_data[4i+3:4i].
- par_valid: out, 1. One-cycle pulse; par_ascii has been updated.
- par_ascii: out, 8*NIBBLES. Byte i is the ASCII code of nibble i.
- char_valid: out, 1. A stream character is available.
- char_ready: in, 1. Consumer accepts the current character.
- char_data: out, 8. Current stream character.
- char_index: out, clog2(NIBBLES). Position in the stream; 0 is the first (MSB) character.
- char_last: out, 1. High together with the final character of the word.

Behaviour:
- Reset (reset_n low, asynchronous) clears:
  - busy, par_valid, char_valid, char_last to 0;
  - par_ascii, char_data, char_index and the captured word to 0.
- in_ready is therefore 1 while in reset and immediately after release.
- Nibble map (combinational core, identical for every digit):
  - n 0-9 gives 0x30+n.
  - n 10-15 gives 0x41+(n-10) when UPPERCASE=1, or 0x61+(n-10) when UPPERCASE=0.
  - No other codes are produced.
- Accept: in_valid & in_ready at a rising edge. Within that edge:
  - in_data is captured;
  - busy is set;
  - par_ascii is loaded with the converted word and par_valid pulses high for exactly that following cycle;
  - char_valid is set, char_index is 0, and char_data holds the ASCII code of nibble NIBBLES-1.
  - Parallel latency is therefore 1 cycle.
- Stream advance: on each edge with char_valid & char_ready:
  - if char_index < NIBBLES-1: char_index increments and char_data becomes the code of nibble NIBBLES-2-char_index (MSB to LSB order);
  - if char_index = NIBBLES-1: char_valid, char_last and busy clear, and in_ready returns high in the next cycle.
  - There is no same-cycle re-accept.
- char_last = char_valid AND (char_index = NIBBLES-1).
- Backpressure: while char_valid=1 and char_ready=0, char_data, char_index and char_last hold stable.
- in_valid while busy is ignored. The captured word and par_ascii are unchanged.
- par_ascii holds its value until the next accept.
- A reset asserted mid-stream aborts immediately. Outputs go to their reset values and the partial stream is discarded.
- Throughput: NIBBLES+1 cycles per word minimum, with char_ready tied high.

Decomposition:
- Shared package hex_ascii_pkg holds:
  - constants ASCII_ZERO=8'h30, ASCII_UPPER_A=8'h41, ASCII_LOWER_A=8'h61;
  - a function nibble_to_ascii(nibble, uppercase).
- One natural sub-module, hex_digit_ascii: a purely combinational 4-bit to 8-bit converter.
  - NIBBLES instances build the parallel image.
  - One instance is muxed by the next index for the stream.
- Top level holds the capture register, the busy/index counter and the output registers.

Test Plan:
- Reset: hold reset_n low 3 cycles, then release. Required: in_ready=1, char_valid=0, par_valid=0, par_ascii=0.
- Parallel image:
  - Stimulus: accept in_data=128'h19a09ae93df4c6f8e3e28d48be2b2a08.
  - Required, one cycle later: par_valid=1 for 1 cycle, byte31=0x31, byte30=0x39, byte29=0x41, byte28=0x30, byte0=0x38.
- Stream order with char_ready=1:
  - Stimulus: accept 128'h2b7e151628aed2a6abf7158809cf4f3c.
  - Required: 32 consecutive characters "2B7E1516...4F3C"; char_index 0..31; char_last only on the final 'C' (0x43); in_ready=1 exactly one cycle after the last handshake.
- Backpressure and ignore:
  - Stimulus: deassert char_ready for 5 cycles at char_index 3 and pulse in_valid with a different word meanwhile.
  - Required: char_data and char_index hold; the stream resumes unchanged; the second word is not captured.
- Boundaries:
  - Stimulus: words of all 0x0 and of all 0xF; repeat with UPPERCASE=0.
  - Required: 0x30 everywhere / 0x46 everywhere; lowercase build gives 0x66.
- Reset mid-stream:
  - Stimulus: assert reset_n low asynchronously at char_index 10.
  - Required: char_valid drops immediately; after release, a new accept streams from index 0.
